load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 20 ++
 rtl/lsu_if.sv | 44 ++++
 rtl/lsu_wait_timer.sv | 30 +++
 rtl/load_store_unit.sv | 111 +++++++++++
 tb/tb_load_store_unit.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types, default widths and sizing helpers for the load/store unit.
package lsu_pkg;

  localparam int unsigned LSU_ADDR_W  = 8;
  localparam int unsigned LSU_DATA_W  = 8;
  localparam int unsigned LSU_TIMEOUT = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_REQ = 2'd1,
    WR_REQ = 2'd2,
    DONE   = 2'd3
  } lsu_state_e;

  // Counter width able to hold limit-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Core request and data-memory handshake bundle; the LSU is the master.
interface lsu_if
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = LSU_ADDR_W,
  parameter int unsigned DATA_W = LSU_DATA_W
);

  logic              req_load;
  logic              req_store;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              busy;
  logic              done;
  logic              error;
  logic [DATA_W-1:0] load_data;
  logic              mem_read_valid;
  logic [ADDR_W-1:0] mem_read_addr;
  logic              mem_read_ready;
  logic [DATA_W-1:0] mem_read_data;
  logic              mem_write_valid;
  logic [ADDR_W-1:0] mem_write_addr;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_write_ready;

  modport master (
    input  req_load, req_store, req_addr, req_wdata,
    output busy, done, error, load_data,
    output mem_read_valid, mem_read_addr,
    input  mem_read_ready, mem_read_data,
    output mem_write_valid, mem_write_addr, mem_write_data,
    input  mem_write_ready
  );

  modport slave (
    output req_load, req_store, req_addr, req_wdata,
    input  busy, done, error, load_data,
    input  mem_read_valid, mem_read_addr,
    output mem_read_ready, mem_read_data,
    input  mem_write_valid, mem_write_addr, mem_write_data,
    output mem_write_ready
  );

endinterface

// File: rtl/lsu_wait_timer.sv
// Wait-cycle counter for a memory handshake; expired flags TIMEOUT-1 reached.
module lsu_wait_timer
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = LSU_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned     CNT_W = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  // Saturates at LAST so expired stays stable until cleared.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit bridging core requests to a valid/ready data memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W  = LSU_ADDR_W,
  parameter int unsigned DATA_W  = LSU_DATA_W,
  parameter int unsigned TIMEOUT = LSU_TIMEOUT
) (
  input logic clk,
  input logic reset,
  lsu_if.master bus
);

  lsu_state_e        state, state_nxt;
  logic              err_q, err_nxt;
  logic              cap_addr, cap_wdata, cap_rdata;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] load_data_q;
  logic              timer_clear, timer_enable, timer_expired;

  assign timer_clear  = (state == IDLE);
  assign timer_enable = ((state == RD_REQ) && !bus.mem_read_ready) ||
                        ((state == WR_REQ) && !bus.mem_write_ready);

  lsu_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .expired (timer_expired)
  );

  // State and error-flag register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      err_q <= err_nxt;
    end
  end

  // Next state; ready is checked before the timeout so a late ack still succeeds.
  always_comb begin
    state_nxt = state;
    err_nxt   = 1'b0;
    cap_addr  = 1'b0;
    cap_wdata = 1'b0;
    cap_rdata = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_load && bus.req_store) begin
          state_nxt = DONE;
          err_nxt   = 1'b1;
        end else if (bus.req_load) begin
          state_nxt = RD_REQ;
          cap_addr  = 1'b1;
        end else if (bus.req_store) begin
          state_nxt = WR_REQ;
          cap_addr  = 1'b1;
          cap_wdata = 1'b1;
        end
      end
      RD_REQ: begin
        if (bus.mem_read_ready) begin
          state_nxt = DONE;
          cap_rdata = 1'b1;
        end else if (timer_expired) begin
          state_nxt = DONE;
          err_nxt   = 1'b1;
        end
      end
      WR_REQ: begin
        if (bus.mem_write_ready) begin
          state_nxt = DONE;
        end else if (timer_expired) begin
          state_nxt = DONE;
          err_nxt   = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request and read-data capture registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      load_data_q <= '0;
    end else begin
      if (cap_addr)  addr_q      <= bus.req_addr;
      if (cap_wdata) wdata_q     <= bus.req_wdata;
      if (cap_rdata) load_data_q <= bus.mem_read_data;
    end
  end

  assign bus.busy            = (state != IDLE);
  assign bus.done            = (state == DONE);
  assign bus.error           = (state == DONE) && err_q;
  assign bus.load_data       = load_data_q;
  assign bus.mem_read_valid  = (state == RD_REQ);
  assign bus.mem_read_addr   = addr_q;
  assign bus.mem_write_valid = (state == WR_REQ);
  assign bus.mem_write_addr  = addr_q;
  assign bus.mem_write_data  = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed and random transactions against a transaction-level model.
module tb_load_store_unit;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;
  localparam int unsigned TO = 16;

  logic clk;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  logic [DW-1:0] mem     [256];
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] exp_load;

  lsu_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  load_store_unit #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One transaction from the current negedge; memory answers after wait_c low-ready cycles.
  task automatic run_txn(input bit ld, input bit st, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd, input int wait_c, input bit poke,
                         input string tag);
    int exp_valid, exp_done_k, exp_rd, exp_wr;
    bit exp_err;
    int rd_cnt, wr_cnt, both, bad, stray, done_k;
    bit err_seen;
    logic [DW-1:0] ld_seen;

    if (ld && st) begin
      exp_valid = 0; exp_err = 1'b1; exp_done_k = 1;
    end else if (wait_c < int'(TO)) begin
      exp_valid = wait_c + 1; exp_err = 1'b0; exp_done_k = exp_valid + 1;
      if (st) ref_mem[addr] = wd;
      if (ld) exp_load = ref_mem[addr];
    end else begin
      exp_valid = int'(TO); exp_err = 1'b1; exp_done_k = int'(TO) + 1;
    end
    exp_rd = (ld && !st) ? exp_valid : 0;
    exp_wr = (st && !ld) ? exp_valid : 0;

    rd_cnt = 0; wr_cnt = 0; both = 0; bad = 0; stray = 0; done_k = 0;
    err_seen = 1'b0; ld_seen = '0;
    bus.req_load  = ld;
    bus.req_store = st;
    bus.req_addr  = addr;
    bus.req_wdata = wd;

    for (int k = 1; k <= 80 && done_k == 0; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.req_load  = 1'b0;
        bus.req_store = 1'b0;
        bus.req_addr  = AW'($urandom);
        bus.req_wdata = DW'($urandom);
      end
      bus.mem_read_ready  = 1'b0;
      bus.mem_write_ready = 1'b0;
      bus.mem_read_data   = DW'($urandom);
      if (bus.mem_read_valid && bus.mem_write_valid) both++;
      if (bus.mem_read_valid) begin
        rd_cnt++;
        if (bus.mem_read_addr !== addr) bad++;
        if (rd_cnt > wait_c) begin
          bus.mem_read_ready = 1'b1;
          bus.mem_read_data  = mem[bus.mem_read_addr];
        end
      end
      if (bus.mem_write_valid) begin
        wr_cnt++;
        if (bus.mem_write_addr !== addr || bus.mem_write_data !== wd) bad++;
        if (wr_cnt > wait_c) begin
          bus.mem_write_ready = 1'b1;
          mem[bus.mem_write_addr] = bus.mem_write_data;
        end
      end
      if (bus.error && !bus.done) stray++;
      if (bus.done) begin
        done_k   = k;
        err_seen = bus.error;
        ld_seen  = bus.load_data;
        if (poke) begin
          bus.req_load = 1'b1;
          bus.req_addr = AW'($urandom);
        end
      end
    end

    check({tag, "/done_latency"}, 32'(done_k), 32'(exp_done_k));
    check({tag, "/rd_valid_cycles"}, 32'(rd_cnt), 32'(exp_rd));
    check({tag, "/wr_valid_cycles"}, 32'(wr_cnt), 32'(exp_wr));
    check({tag, "/both_valid"}, 32'(both), 32'd0);
    check({tag, "/addr_data_stable"}, 32'(bad), 32'd0);
    check({tag, "/error_without_done"}, 32'(stray), 32'd0);
    check({tag, "/error"}, 32'(err_seen), 32'(exp_err));
    check({tag, "/load_data"}, 32'(ld_seen), 32'(exp_load));

    @(negedge clk);
    bus.req_load        = 1'b0;
    bus.mem_read_ready  = 1'b0;
    bus.mem_write_ready = 1'b0;
    check({tag, "/done_one_cycle"}, 32'(bus.done), 32'd0);
    check({tag, "/idle_after_done"}, 32'(bus.busy), 32'd0);
    check({tag, "/mem_contents"}, 32'(mem[addr]), 32'(ref_mem[addr]));
  endtask

  initial begin
    bit ld, st, poke;
    int r, sel, wc;
    logic [AW-1:0] a;

    reset = 1'b1;
    bus.req_load = 1'b0; bus.req_store = 1'b0;
    bus.req_addr = '0;   bus.req_wdata = '0;
    bus.mem_read_ready = 1'b0; bus.mem_write_ready = 1'b0;
    bus.mem_read_data = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = DW'($urandom);
      ref_mem[i] = mem[i];
    end
    exp_load = '0;
    repeat (2) @(negedge clk);

    check("reset/busy", 32'(bus.busy), 32'd0);
    check("reset/done", 32'(bus.done), 32'd0);
    check("reset/error", 32'(bus.error), 32'd0);
    check("reset/rd_valid", 32'(bus.mem_read_valid), 32'd0);
    check("reset/wr_valid", 32'(bus.mem_write_valid), 32'd0);
    check("reset/load_data", 32'(bus.load_data), 32'd0);
    reset = 1'b0;

    run_txn(1'b0, 1'b1, 8'd42, 8'd50, 2,   1'b0, "store42");
    run_txn(1'b1, 1'b0, 8'd42, 8'd0,  0,   1'b0, "load42");
    run_txn(1'b1, 1'b0, 8'd32, 8'd0,  100, 1'b0, "timeout32");
    run_txn(1'b1, 1'b1, 8'd7,  8'd0,  0,   1'b0, "illegal");
    run_txn(1'b1, 1'b0, 8'd5,  8'd0,  15,  1'b0, "ready_wins_rd");
    run_txn(1'b0, 1'b1, 8'd6,  8'd77, 15,  1'b0, "ready_wins_wr");
    run_txn(1'b0, 1'b1, 8'd9,  8'd88, 16,  1'b0, "timeout_wr");
    run_txn(1'b1, 1'b0, 8'd42, 8'd0,  1,   1'b1, "b2b_load");
    run_txn(1'b0, 1'b1, 8'd43, 8'd9,  0,   1'b0, "b2b_store");

    // Reset while a store is waiting for its ack.
    bus.req_store = 1'b1; bus.req_addr = 8'd32; bus.req_wdata = 8'd63;
    @(negedge clk);
    bus.req_store = 1'b0;
    @(negedge clk);
    check("rst_wr/wr_valid_before", 32'(bus.mem_write_valid), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("rst_wr/wr_valid", 32'(bus.mem_write_valid), 32'd0);
    check("rst_wr/busy", 32'(bus.busy), 32'd0);
    check("rst_wr/done", 32'(bus.done), 32'd0);
    check("rst_wr/load_data", 32'(bus.load_data), 32'd0);
    exp_load = '0;
    reset = 1'b0;
    @(negedge clk);
    check("rst_wr/no_done_after", 32'(bus.done), 32'd0);
    check("rst_wr/mem32", 32'(mem[32]), 32'(ref_mem[32]));

    for (int n = 0; n < 24; n++) begin
      r   = int'($urandom_range(0, 9));
      ld  = (r < 5) || (r == 9);
      st  = (r >= 5);
      a   = AW'(40 + $urandom_range(0, 15));
      sel = int'($urandom_range(0, 7));
      wc  = (sel < 4) ? sel : (sel == 4) ? 15 : (sel == 5) ? 16 : int'($urandom_range(0, 20));
      poke = ($urandom_range(0, 3) == 0);
      run_txn(ld, st, a, DW'($urandom), wc, poke, $sformatf("rand%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
